// File: rtl/dwc_vote.sv
// dwc_vote: N-way redundant result checker with majority vote, per-core mismatch
// mask, saturating mismatch counter and interrupt reporting; one compare per three cycles.
//
//   state      | meaning
//   ST_IDLE    | waiting for start; data_in captured on the accepting edge
//   ST_COMPARE | pairwise equality and per-core agree counts registered
//   ST_REPORT  | status, counter and interrupt outputs updated; back to idle
module dwc_vote #(
    parameter int WIDTH    = 32,
    parameter int N_CORES  = 3,
    parameter int CNT_W    = 16,
    parameter int IRQ_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_CORES*WIDTH-1:0] data_in,
    input  logic                     irq_clear,
    input  logic                     cnt_clear,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     match_all,
    output logic                     vote_ok,
    output logic [WIDTH-1:0]         voted_data,
    output logic [N_CORES-1:0]       mismatch_mask,
    output logic [CNT_W-1:0]         mismatch_count,
    output logic                     interrupt,
    output logic                     irq_pending
);
    localparam int NPAIR = N_CORES * N_CORES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_REPORT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cap_q [N_CORES];
    logic [WIDTH-1:0]   cap_d [N_CORES];
    logic [NPAIR-1:0]   eq_q, eq_d, eq_now;
    logic [2:0]         agree_q [N_CORES];
    logic [2:0]         agree_d [N_CORES];

    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;
    logic               match_all_q, match_all_d;
    logic               vote_ok_q, vote_ok_d;
    logic [WIDTH-1:0]   voted_data_q, voted_data_d;
    logic [N_CORES-1:0] mismatch_mask_q, mismatch_mask_d;
    logic [CNT_W-1:0]   mismatch_count_q, mismatch_count_d;
    logic               interrupt_q, interrupt_d;
    logic               irq_pending_q, irq_pending_d;

    logic [N_CORES-1:0] maj;
    logic               vote_found;
    int                 vote_idx;
    logic [WIDTH-1:0]   vote_word;
    logic [N_CORES-1:0] mask_calc;
    logic               all_equal;
    logic               fire;

    // Bit i*N_CORES+j set when captured core i equals captured core j.
    always_comb begin
        eq_now = '0;
        for (int i = 0; i < N_CORES; i++) begin
            for (int j = 0; j < N_CORES; j++) begin
                eq_now[i*N_CORES + j] = (cap_q[i] == cap_q[j]);
            end
        end
    end

    // Report-side decode works only from the registered compare results.
    always_comb begin
        maj        = '0;
        vote_found = 1'b0;
        vote_idx   = 0;
        vote_word  = cap_q[0];
        mask_calc  = '1;
        for (int i = 0; i < N_CORES; i++) begin
            maj[i] = (int'(agree_q[i]) * 2 > N_CORES);
        end
        for (int i = 0; i < N_CORES; i++) begin
            if (maj[i] && !vote_found) begin
                vote_found = 1'b1;
                vote_idx   = i;
                vote_word  = cap_q[i];
            end
        end
        if (vote_found) begin
            for (int i = 0; i < N_CORES; i++) begin
                mask_calc[i] = !eq_q[i*N_CORES + vote_idx];
            end
        end
        all_equal = &eq_q;
        fire      = (IRQ_MODE != 0) || !all_equal;
    end

    always_comb begin
        state_d          = state_q;
        cap_d            = cap_q;
        eq_d             = eq_q;
        agree_d          = agree_q;
        result_valid_d   = 1'b0;
        interrupt_d      = 1'b0;
        match_all_d      = match_all_q;
        vote_ok_d        = vote_ok_q;
        voted_data_d     = voted_data_q;
        mismatch_mask_d  = mismatch_mask_q;
        mismatch_count_d = mismatch_count_q;
        irq_pending_d    = irq_pending_q;

        if (cnt_clear) mismatch_count_d = '0;
        if (irq_clear) irq_pending_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_CORES; i++) begin
                        cap_d[i] = data_in[i*WIDTH +: WIDTH];
                    end
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                eq_d = eq_now;
                for (int i = 0; i < N_CORES; i++) begin
                    agree_d[i] = '0;
                    for (int j = 0; j < N_CORES; j++) begin
                        agree_d[i] = agree_d[i] + {2'b00, eq_now[i*N_CORES + j]};
                    end
                end
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                result_valid_d  = 1'b1;
                match_all_d     = all_equal;
                vote_ok_d       = vote_found;
                voted_data_d    = vote_word;
                mismatch_mask_d = mask_calc;
                // Increment after any clear so a coincident clear yields 1.
                if (!all_equal && (mismatch_count_d != CNT_MAX)) begin
                    mismatch_count_d = mismatch_count_d + CNT_W'(1);
                end
                if (fire) begin
                    interrupt_d   = 1'b1;
                    irq_pending_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < N_CORES; i++) begin
                cap_q[i]   <= '0;
                agree_q[i] <= '0;
            end
            eq_q             <= '0;
            busy_q           <= 1'b0;
            result_valid_q   <= 1'b0;
            match_all_q      <= 1'b0;
            vote_ok_q        <= 1'b0;
            voted_data_q     <= '0;
            mismatch_mask_q  <= '0;
            mismatch_count_q <= '0;
            interrupt_q      <= 1'b0;
            irq_pending_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cap_q            <= cap_d;
            agree_q          <= agree_d;
            eq_q             <= eq_d;
            busy_q           <= busy_d;
            result_valid_q   <= result_valid_d;
            match_all_q      <= match_all_d;
            vote_ok_q        <= vote_ok_d;
            voted_data_q     <= voted_data_d;
            mismatch_mask_q  <= mismatch_mask_d;
            mismatch_count_q <= mismatch_count_d;
            interrupt_q      <= interrupt_d;
            irq_pending_q    <= irq_pending_d;
        end
    end

    assign busy           = busy_q;
    assign result_valid   = result_valid_q;
    assign match_all      = match_all_q;
    assign vote_ok        = vote_ok_q;
    assign voted_data     = voted_data_q;
    assign mismatch_mask  = mismatch_mask_q;
    assign mismatch_count = mismatch_count_q;
    assign interrupt      = interrupt_q;
    assign irq_pending    = irq_pending_q;

endmodule

// File: tb/tb_dwc_vote.sv
// Scoreboard bench for dwc_vote: directed compares push hand-computed results,
// a negedge monitor pops and checks them whenever result_valid is seen.
module tb_dwc_vote;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*W-1:0]   data_in;
    logic             irq_clear;
    logic             cnt_clear;
    logic             busy;
    logic             result_valid;
    logic             match_all;
    logic             vote_ok;
    logic [W-1:0]     voted_data;
    logic [N-1:0]     mismatch_mask;
    logic [CW-1:0]    mismatch_count;
    logic             interrupt;
    logic             irq_pending;

    dwc_vote #(.WIDTH(W), .N_CORES(N), .CNT_W(CW), .IRQ_MODE(0)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .irq_clear(irq_clear), .cnt_clear(cnt_clear), .busy(busy),
        .result_valid(result_valid), .match_all(match_all), .vote_ok(vote_ok),
        .voted_data(voted_data), .mismatch_mask(mismatch_mask),
        .mismatch_count(mismatch_count), .interrupt(interrupt),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            t;
        logic          m;
        logic          v;
        logic [W-1:0]  vd;
        logic [N-1:0]  mask;
        logic          irq;
        logic [CW-1:0] cnt;
        logic          pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_valid", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency",        64'(cyc),            64'(mon_e.t + 2));
                    chk("match_all",      64'(match_all),      64'(mon_e.m));
                    chk("vote_ok",        64'(vote_ok),        64'(mon_e.v));
                    chk("voted_data",     64'(voted_data),     64'(mon_e.vd));
                    chk("mismatch_mask",  64'(mismatch_mask),  64'(mon_e.mask));
                    chk("interrupt",      64'(interrupt),      64'(mon_e.irq));
                    chk("mismatch_count", 64'(mismatch_count), 64'(mon_e.cnt));
                    chk("irq_pending",    64'(irq_pending),    64'(mon_e.pend));
                end
            end else if (interrupt) begin
                chk("interrupt_without_valid", 64'(interrupt), 64'd0);
            end
        end
    end

    task automatic push_exp(input logic m, input logic v, input logic [W-1:0] vd,
                            input logic [N-1:0] mask, input logic irq,
                            input logic [CW-1:0] cnt, input logic pend);
        exp_t e;
        e.t = cyc; e.m = m; e.v = v; e.vd = vd; e.mask = mask;
        e.irq = irq; e.cnt = cnt; e.pend = pend;
        exp_q.push_back(e);
    endtask

    // One compare; returns #1 after the REPORT edge so the next start lands on T+3.
    task automatic do_cmp(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                          input logic m, input logic v, input logic [W-1:0] vd,
                          input logic [N-1:0] mask, input logic irq,
                          input logic [CW-1:0] cnt, input logic pend, input bit clr_at_report);
        @(negedge clk);
        data_in = {d2, d1, d0};
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = ~data_in;
        push_exp(m, v, vd, mask, irq, cnt, pend);
        @(posedge clk); #1;
        chk("busy_mid_compare", 64'(busy), 64'd1);
        if (clr_at_report) cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},           64'(busy),           64'd0);
        chk({tag, "_result_valid"},   64'(result_valid),   64'd0);
        chk({tag, "_match_all"},      64'(match_all),      64'd0);
        chk({tag, "_vote_ok"},        64'(vote_ok),        64'd0);
        chk({tag, "_voted_data"},     64'(voted_data),     64'd0);
        chk({tag, "_mismatch_mask"},  64'(mismatch_mask),  64'd0);
        chk({tag, "_mismatch_count"}, 64'(mismatch_count), 64'd0);
        chk({tag, "_interrupt"},      64'(interrupt),      64'd0);
        chk({tag, "_irq_pending"},    64'(irq_pending),    64'd0);
    endtask

    logic [CW-1:0] sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; irq_clear = 1'b0; cnt_clear = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        do_cmp(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 3'b000, 0, 2'd0, 0, 0);
        do_cmp(32'h1, 32'h1, 32'h5, 0, 1, 32'h1, 3'b100, 1, 2'd1, 1, 0);

        @(negedge clk); irq_clear = 1'b1;
        @(posedge clk); #1; irq_clear = 1'b0;
        chk("irq_clear", 64'(irq_pending), 64'd0);

        do_cmp(32'h1, 32'h2, 32'h3, 0, 0, 32'h1, 3'b111, 1, 2'd2, 1, 0);
        do_cmp(32'h5, 32'h1, 32'h1, 0, 1, 32'h1, 3'b001, 1, 2'd3, 1, 0);
        do_cmp(32'h7, 32'h9, 32'h7, 0, 1, 32'h7, 3'b010, 1, 2'd3, 1, 0);

        @(negedge clk); cnt_clear = 1'b1;
        @(posedge clk); #1; cnt_clear = 1'b0;
        chk("cnt_clear_idle", 64'(mismatch_count), 64'd0);

        for (int k = 0; k < 5; k++) begin
            do_cmp(32'h10 + k, 32'h10 + k, 32'h20, 0, 1, 32'h10 + k, 3'b100, 1, sat_seq[k], 1, 0);
        end
        do_cmp(32'h30, 32'h31, 32'h30, 0, 1, 32'h30, 3'b010, 1, 2'd1, 1, 1);
        do_cmp(32'hAA, 32'hAA, 32'hAA, 1, 1, 32'hAA, 3'b000, 0, 2'd1, 1, 0);

        // start held through T+1 and T+2 must be ignored; start at T+3 accepted
        @(negedge clk);
        data_in = {32'h44, 32'h44, 32'h44};
        start   = 1'b1;
        @(posedge clk); #1;
        push_exp(1, 1, 32'h44, 3'b000, 0, 2'd1, 1);
        data_in = {32'h97, 32'h98, 32'h99};
        @(posedge clk);
        @(posedge clk); #1;
        data_in = {32'h55, 32'h66, 32'h55};
        @(posedge clk); #1;
        start   = 1'b0;
        push_exp(0, 1, 32'h55, 3'b010, 1, 2'd2, 1);
        repeat (3) @(posedge clk);
        #1;

        // reset one cycle into a mismatching compare
        @(negedge clk);
        data_in = {32'h3, 32'h2, 32'h1};
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        #1;
        chk_all_zero("abort");
        repeat (3) begin
            @(negedge clk);
            chk("irq_during_reset", 64'(interrupt), 64'd0);
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("irq_after_abort",   64'(interrupt),    64'd0);
            chk("valid_after_abort", 64'(result_valid), 64'd0);
        end

        do_cmp(32'hA, 32'hB, 32'hA, 0, 1, 32'hA, 3'b010, 1, 2'd1, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
